accel_ctrl_fsm: RTL and testbench

Parametrised top-level sequencer for the cryptography accelerator. It steps the datapath through receive, hash and send phases for a programmable batch of messages. It counts a configurable number of `second_tick` pulses per hash phase and guards the host-facing phases with a cycle timeout that drops into a sticky error state. It sits between the UART receive/transmit blocks and the hash core, driving their enables.

---
 rtl/accel_ctrl_fsm.sv | 145 ++++++++++++++
 tb/tb_accel_ctrl_fsm.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_ctrl_fsm.sv
// accel_ctrl_fsm: batch sequencer for the crypto accelerator.
// Steps through RECEIVING -> HASHING -> SENDING once per message of a batch.
// The host-facing phases are guarded by a saturating cycle timeout that
// drops into a sticky ERROR state.
// Optional build macro: ACCEL_CTRL_EARLY_DONE_EN lets hash_done end HASHING early.
module accel_ctrl_fsm #(
    parameter int unsigned HASH_TICKS     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned BATCH_W        = 8
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               start,
    input  logic [BATCH_W-1:0] batch_len,
    input  logic               finished_recieving,
    input  logic               finished_sending,
    input  logic               second_tick,
    input  logic               hash_done,
    input  logic               clear_err,
    output logic               read_enable,
    output logic               hash_enable,
    output logic               write_enable,
    output logic               busy,
    output logic               timeout_err,
    output logic [BATCH_W-1:0] batch_remaining,
    output logic [2:0]         state_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] TickLast = 8'(HASH_TICKS - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRecv  = 3'd1,
        StHash  = 3'd2,
        StSend  = 3'd3,
        StError = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic [7:0]         tick_q, tick_d;
    logic [BATCH_W-1:0] batch_q, batch_d;

    logic            tmo_hit;
    logic [TmoW-1:0] tmo_inc;
    logic            hash_exit;

    // Timeout counter stops at its terminal value instead of wrapping.
    assign tmo_hit = (tmo_q == TmoLast);
    assign tmo_inc = tmo_hit ? tmo_q : tmo_q + 1'b1;

`ifdef ACCEL_CTRL_EARLY_DONE_EN
    assign hash_exit = hash_done || (second_tick && (tick_q == TickLast));
`else
    logic unused_hash_done;
    assign unused_hash_done = hash_done;
    assign hash_exit = second_tick && (tick_q == TickLast);
`endif

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= StIdle;
            tmo_q   <= '0;
            tick_q  <= '0;
            batch_q <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            tick_q  <= tick_d;
            batch_q <= batch_d;
        end
    end

    // Next-state and counter updates; completion takes priority over timeout.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        tick_d  = tick_q;
        batch_d = batch_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    batch_d = (batch_len == '0) ? BATCH_W'(1) : batch_len;
                    tmo_d   = '0;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                tmo_d = tmo_inc;
                if (finished_recieving) begin
                    tick_d  = '0;
                    state_d = StHash;
                end else if (tmo_hit) begin
                    state_d = StError;
                end
            end
            StHash: begin
                if (second_tick) begin
                    tick_d = tick_q + 8'd1;
                end
                if (hash_exit) begin
                    tmo_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                tmo_d = tmo_inc;
                if (finished_sending) begin
                    if (batch_q > BATCH_W'(1)) begin
                        batch_d = batch_q - 1'b1;
                        tmo_d   = '0;
                        state_d = StRecv;
                    end else begin
                        batch_d = '0;
                        state_d = StIdle;
                    end
                end else if (tmo_hit) begin
                    state_d = StError;
                end
            end
            StError: begin
                if (clear_err) begin
                    batch_d = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                // Unreachable encodings recover to IDLE.
                state_d = StIdle;
            end
        endcase
    end

    assign read_enable     = (state_q == StRecv);
    assign hash_enable     = (state_q == StHash);
    assign write_enable    = (state_q == StSend);
    assign busy            = read_enable | hash_enable | write_enable;
    assign timeout_err     = (state_q == StError);
    assign batch_remaining = batch_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_accel_ctrl_fsm.sv
// Self-checking bench for accel_ctrl_fsm: directed scenarios plus randomized
// traffic compared each cycle against a phase-level reference model.
module tb_accel_ctrl_fsm;

    localparam int HT  = 3;
    localparam int TMO = 10;
    localparam int BW  = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] batch_len = '0;
    logic          finished_recieving = 1'b0;
    logic          finished_sending = 1'b0;
    logic          second_tick = 1'b0;
    logic          hash_done = 1'b0;
    logic          clear_err = 1'b0;
    logic          read_enable, hash_enable, write_enable, busy, timeout_err;
    logic [BW-1:0] batch_remaining;
    logic [2:0]    state_o;

    int passed = 0;
    int total  = 0;

    // Reference model: phase number (0 idle .. 4 error), messages left,
    // cycles spent in the current host phase, ticks seen while hashing.
    int m_phase = 0;
    int m_batch = 0;
    int m_wait  = 0;
    int m_ticks = 0;

    accel_ctrl_fsm #(
        .HASH_TICKS    (HT),
        .TIMEOUT_CYCLES(TMO),
        .BATCH_W       (BW)
    ) dut (
        .clk               (clk),
        .rst_i             (rst_i),
        .start             (start),
        .batch_len         (batch_len),
        .finished_recieving(finished_recieving),
        .finished_sending  (finished_sending),
        .second_tick       (second_tick),
        .hash_done         (hash_done),
        .clear_err         (clear_err),
        .read_enable       (read_enable),
        .hash_enable       (hash_enable),
        .write_enable      (write_enable),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .batch_remaining   (batch_remaining),
        .state_o           (state_o)
    );

    always #5 clk = ~clk;

    logic [15:0] dut_vec;
    assign dut_vec = {read_enable, hash_enable, write_enable, busy, timeout_err,
                      batch_remaining, state_o};

    function automatic logic [15:0] exp_vec();
        logic [BW-1:0] b;
        logic [2:0]    p;
        b = BW'(m_batch);
        p = 3'(m_phase);
        return {m_phase == 1, m_phase == 2, m_phase == 3,
                (m_phase >= 1 && m_phase <= 3), m_phase == 4, b, p};
    endfunction

    task automatic model_step();
        if (rst_i) begin
            m_phase = 0; m_batch = 0; m_wait = 0; m_ticks = 0;
            return;
        end
        case (m_phase)
            0: if (start) begin
                m_batch = (batch_len == 0) ? 1 : int'(batch_len);
                m_wait  = 0;
                m_phase = 1;
            end
            1: begin
                m_wait++;
                if (finished_recieving) begin
                    m_ticks = 0;
                    m_phase = 2;
                end else if (m_wait >= TMO) begin
                    m_phase = 4;
                end
            end
            2: begin
                if (second_tick) m_ticks++;
`ifdef ACCEL_CTRL_EARLY_DONE_EN
                if (hash_done) m_phase = 3;
`endif
                if (second_tick && m_ticks == HT) m_phase = 3;
                if (m_phase == 3) m_wait = 0;
            end
            3: begin
                m_wait++;
                if (finished_sending) begin
                    if (m_batch > 1) begin
                        m_batch--;
                        m_wait  = 0;
                        m_phase = 1;
                    end else begin
                        m_batch = 0;
                        m_phase = 0;
                    end
                end else if (m_wait >= TMO) begin
                    m_phase = 4;
                end
            end
            default: if (clear_err) begin
                m_batch = 0;
                m_phase = 0;
            end
        endcase
    endtask

    // Advance one clock: model samples the same inputs as the DUT edge.
    task automatic tick_clk();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            second_tick = 1'b1;
            tick_clk();
            second_tick = 1'b0;
        end
    endtask

    task automatic go_to_send(input int len);
        batch_len = BW'(len);
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        finished_recieving = 1'b1;
        tick_clk();
        finished_recieving = 1'b0;
        pulse_ticks(HT);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick_clk();
        tick_clk();
        rst_i = 1'b0;
        total++;
        if (state_o !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_o);
        else passed++;
        total++;
        if ({read_enable, hash_enable, write_enable} !== 3'b000)
            $display("FAIL reset_enables: got %b want 000",
                     {read_enable, hash_enable, write_enable});
        else passed++;
        total++;
        if ({busy, timeout_err} !== 2'b00)
            $display("FAIL reset_busy_err: got %b want 00", {busy, timeout_err});
        else passed++;
        total++;
        if (batch_remaining !== '0) $display("FAIL reset_batch: got %0d want 0", batch_remaining);
        else passed++;
    endtask

    task automatic test_single();
        batch_len = 8'd1;
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        total++;
        if (state_o !== 3'd1 || read_enable !== 1'b1)
            $display("FAIL single_recv: state=%0d rd=%b want 1/1", state_o, read_enable);
        else passed++;
        total++;
        if (batch_remaining !== 8'd1) $display("FAIL single_batch: got %0d want 1", batch_remaining);
        else passed++;
        repeat (3) tick_clk();
        finished_recieving = 1'b1;
        tick_clk();
        finished_recieving = 1'b0;
        total++;
        if (state_o !== 3'd2 || hash_enable !== 1'b1)
            $display("FAIL single_hash: state=%0d he=%b want 2/1", state_o, hash_enable);
        else passed++;
        repeat (4) tick_clk();
        pulse_ticks(HT);
        total++;
        if (state_o !== 3'd3 || write_enable !== 1'b1 || busy !== 1'b1)
            $display("FAIL single_send: state=%0d we=%b busy=%b want 3/1/1",
                     state_o, write_enable, busy);
        else passed++;
        repeat (5) tick_clk();
        finished_sending = 1'b1;
        tick_clk();
        finished_sending = 1'b0;
        total++;
        if (state_o !== 3'd0 || busy !== 1'b0 || batch_remaining !== 8'd0)
            $display("FAIL single_done: state=%0d busy=%b batch=%0d want 0/0/0",
                     state_o, busy, batch_remaining);
        else passed++;
    endtask

    task automatic test_multi_tick();
        batch_len = 8'd2;
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        finished_recieving = 1'b1;
        tick_clk();
        finished_recieving = 1'b0;
        for (int i = 1; i < HT; i++) begin
            pulse_ticks(1);
            tick_clk();
            total++;
            if (state_o !== 3'd2) $display("FAIL multi_hold_tick%0d: state=%0d want 2", i, state_o);
            else passed++;
        end
        pulse_ticks(1);
        total++;
        if (state_o !== 3'd3) $display("FAIL multi_exit: state=%0d want 3", state_o);
        else passed++;
        finished_sending = 1'b1;
        tick_clk();
        finished_sending = 1'b0;
        total++;
        if (state_o !== 3'd1 || batch_remaining !== 8'd1)
            $display("FAIL multi_next: state=%0d batch=%0d want 1/1", state_o, batch_remaining);
        else passed++;
        finished_recieving = 1'b1;
        tick_clk();
        finished_recieving = 1'b0;
        pulse_ticks(HT);
        finished_sending = 1'b1;
        tick_clk();
        finished_sending = 1'b0;
        total++;
        if (state_o !== 3'd0 || batch_remaining !== 8'd0)
            $display("FAIL multi_end: state=%0d batch=%0d want 0/0", state_o, batch_remaining);
        else passed++;
    endtask

    task automatic test_recv_timeout();
        int n;
        batch_len = 8'd5;
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        n = 0;
        while (state_o == 3'd1 && n < 3 * TMO) begin
            tick_clk();
            n++;
        end
        total++;
        if (n !== TMO) $display("FAIL recv_timeout_cycles: got %0d want %0d", n, TMO);
        else passed++;
        total++;
        if (state_o !== 3'd4 || timeout_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL recv_timeout_err: state=%0d err=%b busy=%b want 4/1/0",
                     state_o, timeout_err, busy);
        else passed++;
        start = 1'b1;
        finished_recieving = 1'b1;
        repeat (3) tick_clk();
        start = 1'b0;
        finished_recieving = 1'b0;
        total++;
        if (state_o !== 3'd4 || batch_remaining !== 8'd5)
            $display("FAIL error_sticky: state=%0d batch=%0d want 4/5", state_o, batch_remaining);
        else passed++;
        clear_err = 1'b1;
        tick_clk();
        clear_err = 1'b0;
        total++;
        if (state_o !== 3'd0 || batch_remaining !== 8'd0 || timeout_err !== 1'b0)
            $display("FAIL clear_err: state=%0d batch=%0d err=%b want 0/0/0",
                     state_o, batch_remaining, timeout_err);
        else passed++;
    endtask

    task automatic test_tie();
        go_to_send(1);
        repeat (TMO - 1) tick_clk();
        total++;
        if (state_o !== 3'd3) $display("FAIL tie_pre: state=%0d want 3", state_o);
        else passed++;
        finished_sending = 1'b1;
        tick_clk();
        finished_sending = 1'b0;
        total++;
        if (state_o !== 3'd0 || timeout_err !== 1'b0)
            $display("FAIL tie_exit: state=%0d err=%b want 0/0", state_o, timeout_err);
        else passed++;
        go_to_send(1);
        repeat (TMO) tick_clk();
        total++;
        if (state_o !== 3'd4) $display("FAIL send_timeout: state=%0d want 4", state_o);
        else passed++;
        clear_err = 1'b1;
        tick_clk();
        clear_err = 1'b0;
    endtask

    task automatic test_early_done();
        batch_len = 8'd1;
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        finished_recieving = 1'b1;
        tick_clk();
        finished_recieving = 1'b0;
        tick_clk();
        hash_done = 1'b1;
        tick_clk();
        hash_done = 1'b0;
`ifdef ACCEL_CTRL_EARLY_DONE_EN
        total++;
        if (state_o !== 3'd3) $display("FAIL early_done: state=%0d want 3", state_o);
        else passed++;
`else
        total++;
        if (state_o !== 3'd2) $display("FAIL done_ignored: state=%0d want 2", state_o);
        else passed++;
        pulse_ticks(HT - 1);
        total++;
        if (state_o !== 3'd2) $display("FAIL done_ignored_hold: state=%0d want 2", state_o);
        else passed++;
        pulse_ticks(1);
        total++;
        if (state_o !== 3'd3) $display("FAIL done_ignored_exit: state=%0d want 3", state_o);
        else passed++;
`endif
        finished_sending = 1'b1;
        tick_clk();
        finished_sending = 1'b0;
    endtask

    task automatic test_abort();
        go_to_send(3);
        total++;
        if (state_o !== 3'd3 || batch_remaining !== 8'd3)
            $display("FAIL abort_pre: state=%0d batch=%0d want 3/3", state_o, batch_remaining);
        else passed++;
        rst_i = 1'b1;
        tick_clk();
        rst_i = 1'b0;
        total++;
        if (dut_vec !== 16'h0000) $display("FAIL abort_outputs: got %h want 0000", dut_vec);
        else passed++;
        batch_len = 8'd0;
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        total++;
        if (state_o !== 3'd1 || batch_remaining !== 8'd1)
            $display("FAIL abort_restart: state=%0d batch=%0d want 1/1", state_o, batch_remaining);
        else passed++;
        rst_i = 1'b1;
        tick_clk();
        rst_i = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst_i              = ($urandom_range(0, 199) == 0);
            start              = ($urandom_range(0, 7) == 0);
            batch_len          = BW'($urandom_range(0, 4));
            finished_recieving = ($urandom_range(0, 3) == 0);
            finished_sending   = ($urandom_range(0, 3) == 0);
            second_tick        = ($urandom_range(0, 1) == 0);
            hash_done          = ($urandom_range(0, 5) == 0);
            clear_err          = ($urandom_range(0, 3) == 0);
            tick_clk();
            total++;
            if (dut_vec !== exp_vec())
                $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
            else passed++;
        end
        {rst_i, start, finished_recieving, finished_sending} = 4'b0;
        {second_tick, hash_done, clear_err} = 3'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_single();
        test_multi_tick();
        test_recv_timeout();
        test_tie();
        test_early_done();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
